elev_disp_anim: RTL and testbench
=================================

# elev_disp_anim

Parametrised elevator floor display driver for one active-high 7-segment digit. It shows the current floor as a decimal digit when the car is idle, and plays a three-frame travelling-segment animation interleaved with the floor digit when moving up or down. A stop/alarm mode blinks the digit, and out-of-range floors display "E". It sits between the elevator controller (floor index and direction) and the display pins, and replaces the fixed 3-code floor decoder.

## Interface
- FLOORS, 3, number of valid floors; legal 1..10, digits 0..FLOORS-1
- TICK_DIV, 25_000_000, clk cycles per animation frame; legal ≥2
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- floor  in  4  binary floor index
- dir  in  2  00 idle, 01 up, 10 down, 11 stop/alarm
- seg  out  7  {a,b,c,d,e,f,g}, seg[6]=a … seg[0]=g, 1 = segment lit
- err  out  1  high while registered floor ≥ FLOORS
- tick  out  1  one-cycle pulse on every frame boundary

## Operation
- Input stage: floor_q and dir_q are registered from floor and dir every clk. All logic uses the registered copies.
- Digit codes (seg): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, E=1001111, blank=0000000.
- "Floor glyph": the digit for floor_q if floor_q < FLOORS, else E. err=1 exactly when E would be chosen, regardless of state.
- Frame glyphs: BOT=0001000 (d), MID=0000001 (g), TOP=1000000 (a).
- FSM states: IDLE, UP1, UP2, UP3, UPF, DN1, DN2, DN3, DNF, STON, STOFF.
- Mode change: each state belongs to a mode (IDLE→00, UP*→01, DN*→10, ST*→11). When dir_q ≠ mode(state), on that edge:
  - state loads the entry state of the new mode: IDLE, UP1, DN1 or STON;
  - the frame counter clears to 0.
  - Mode change has priority over tick.
- Frame counter: counts 0..TICK_DIV-1 and wraps. tick=1 in the cycle where count==TICK_DIV-1 and no mode change occurs. In IDLE the counter runs but ticks do not change state.
- On tick:
  - UP1→UP2→UP3→UPF→UP1;
  - DN1→DN2→DN3→DNF→DN1;
  - STON↔STOFF.
- seg per state:
  - IDLE, UPF, DNF, STON: floor glyph;
  - UP1=BOT, UP2=MID, UP3=TOP;
  - DN1=TOP, DN2=MID, DN3=BOT;
  - STOFF=blank.
- A floor_q change while showing the floor glyph updates the glyph immediately. It never restarts the animation.
- Counter width is clog2(TICK_DIV). The counter never exceeds TICK_DIV-1.

## Timing
- seg, err, tick and state are registered and update on the same edge.
- Reset (rst high at an edge) sets:
  - floor_q=0, dir_q=00;
  - state=IDLE, count=0;
  - seg=0000000, err=0, tick=0.
- First edge after rst deasserts: seg=1111110 (floor 0).
- rst asserted mid-animation: on the next edge all registers return to reset values. Reset overrides a mode change or tick on the same edge.
- Input-to-output latency is 2 edges. An input changed before edge N is captured at N; seg reflects it at edge N+1.
- After a mode change, the first frame lasts exactly TICK_DIV cycles. Every later frame also lasts TICK_DIV cycles.
- A dir glitch of one cycle still causes a mode change and then a change back. Each change restarts the frame counter.
- dir returning to the same mode mid-animation causes no restart.

## Test plan
Run the bench with TICK_DIV=4.

1. Reset and idle:
   - Drive rst for 2 cycles, then release with floor=0, dir=00 → seg=0000000 during reset; seg=1111110, err=0 one edge after release.
2. Floor sweep and out-of-range (FLOORS=10, then FLOORS=3):
   - FLOORS=10, floor=0..9 idle → the 10 digit codes, each 2 edges after input change.
   - FLOORS=3, floor=3 → seg=1001111, err=1.
3. Up animation:
   - floor=2, dir=01 → sequence 0001000, 0000001, 1000000, 1101101, 0001000, each held 4 cycles.
   - tick pulses on the last cycle of each frame.
4. Down mode switch mid-frame:
   - During UP2 with count=1, set dir=10 → next edge after capture shows 1000000 (DN1) and the counter restarts.
   - DN1 is held 4 cycles, then 0000001.
5. Stop blink with out-of-range floor:
   - FLOORS=3, floor=5, dir=11 → seg alternates 1001111 / 0000000 every 4 cycles, err=1 throughout.
6. Reset mid-animation:
   - rst=1 during UP3 → seg=0000000, tick=0 next edge.
   - After release with dir still 01 → IDLE digit for 1 edge, then UP1 (0001000) held 4 cycles.

Source files
------------

// File: rtl/elev_disp_anim.sv
// Elevator floor display driver: floor digit when idle, travelling-segment
// animation interleaved with the digit when moving, blinking digit in stop mode.
module elev_disp_anim #(
    parameter int FLOORS   = 3,
    parameter int TICK_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] floor,
    input  logic [1:0] dir,
    output logic [6:0] seg,
    output logic       err,
    output logic       tick
);

    localparam int              CW        = $clog2(TICK_DIV);
    localparam logic [CW-1:0]   LAST      = CW'(TICK_DIV - 1);
    localparam logic [3:0]      FLOOR_LIM = 4'(FLOORS);

    localparam logic [6:0] GLYPH_E     = 7'b1001111;
    localparam logic [6:0] GLYPH_BLANK = 7'b0000000;
    localparam logic [6:0] GLYPH_BOT   = 7'b0001000;
    localparam logic [6:0] GLYPH_MID   = 7'b0000001;
    localparam logic [6:0] GLYPH_TOP   = 7'b1000000;

    typedef enum logic [3:0] {
        IDLE, UP1, UP2, UP3, UPF, DN1, DN2, DN3, DNF, STON, STOFF
    } state_t;

    function automatic logic [1:0] mode_of(input state_t s);
        case (s)
            IDLE:               return 2'b00;
            UP1, UP2, UP3, UPF: return 2'b01;
            DN1, DN2, DN3, DNF: return 2'b10;
            default:            return 2'b11;
        endcase
    endfunction

    function automatic state_t entry_of(input logic [1:0] m);
        case (m)
            2'b00:   return IDLE;
            2'b01:   return UP1;
            2'b10:   return DN1;
            default: return STON;
        endcase
    endfunction

    function automatic logic [6:0] digit_code(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1111110;
            4'd1:    return 7'b0110000;
            4'd2:    return 7'b1101101;
            4'd3:    return 7'b1111001;
            4'd4:    return 7'b0110011;
            4'd5:    return 7'b1011011;
            4'd6:    return 7'b1011111;
            4'd7:    return 7'b1110000;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1111011;
            default: return GLYPH_E;
        endcase
    endfunction

    logic [3:0]    floor_q;
    logic [1:0]    dir_q;
    state_t        state, state_next;
    logic [CW-1:0] count, count_next;
    logic          mode_change, out_of_range, tick_next;
    logic [6:0]    floor_glyph, seg_next;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_next   = state;
        count_next   = (count == LAST) ? '0 : count + CW'(1);
        mode_change  = (dir_q != mode_of(state));
        out_of_range = (floor_q >= FLOOR_LIM);
        floor_glyph  = out_of_range ? GLYPH_E : digit_code(floor_q);

        // tick is registered high by construction only when no mode change is pending
        if (mode_change) begin
            state_next = entry_of(dir_q);
            count_next = '0;
        end else if (tick) begin
            case (state)
                UP1:     state_next = UP2;
                UP2:     state_next = UP3;
                UP3:     state_next = UPF;
                UPF:     state_next = UP1;
                DN1:     state_next = DN2;
                DN2:     state_next = DN3;
                DN3:     state_next = DNF;
                DNF:     state_next = DN1;
                STON:    state_next = STOFF;
                STOFF:   state_next = STON;
                default: state_next = state;
            endcase
        end

        // dir_q loads dir on this edge, so dir predicts next cycle's mode check
        tick_next = (count_next == LAST) && (dir == mode_of(state_next));

        case (state_next)
            UP1, DN3: seg_next = GLYPH_BOT;
            UP2, DN2: seg_next = GLYPH_MID;
            UP3, DN1: seg_next = GLYPH_TOP;
            STOFF:    seg_next = GLYPH_BLANK;
            default:  seg_next = floor_glyph;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            floor_q <= '0;
            dir_q   <= '0;
            state   <= IDLE;
            count   <= '0;
            seg     <= '0;
            err     <= 1'b0;
            tick    <= 1'b0;
        end else begin
            floor_q <= floor;
            dir_q   <= dir;
            state   <= state_next;
            count   <= count_next;
            seg     <= seg_next;
            err     <= out_of_range;
            tick    <= tick_next;
        end
    end

endmodule

// File: tb/tb_elev_disp_anim.sv
// Scoreboard bench for elev_disp_anim: FLOORS=10 and FLOORS=3 instances share
// stimulus; expectations are queued per target cycle and checked on negedge.
module tb_elev_disp_anim;

    localparam int TD = 4;

    localparam logic [6:0] DIG [10] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
    };
    localparam logic [6:0] G_E   = 7'b1001111;
    localparam logic [6:0] G_BOT = 7'b0001000;
    localparam logic [6:0] G_MID = 7'b0000001;
    localparam logic [6:0] G_TOP = 7'b1000000;
    localparam logic [6:0] G_OFF = 7'b0000000;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] floor;
    logic [1:0] dir;
    logic [6:0] seg10, seg3;
    logic       err10, err3, tick10, tick3;

    elev_disp_anim #(.FLOORS(10), .TICK_DIV(TD)) dut10 (
        .clk(clk), .rst(rst), .floor(floor), .dir(dir),
        .seg(seg10), .err(err10), .tick(tick10)
    );

    elev_disp_anim #(.FLOORS(3), .TICK_DIV(TD)) dut3 (
        .clk(clk), .rst(rst), .floor(floor), .dir(dir),
        .seg(seg3), .err(err3), .tick(tick3)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        int         unit;     // 0 = FLOORS 10, 1 = FLOORS 3
        logic [6:0] seg;
        logic       err;
        logic       tick;
        bit         chk_tick;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic push(input int t, input int unit, input logic [6:0] s, input logic e,
                        input logic tk, input bit ct, input string tag);
        sb.push_back('{t, unit, s, e, tk, ct, tag});
    endtask

    task automatic push_both(input int t, input logic [6:0] s, input logic tk, input string tag);
        push(t, 0, s, 1'b0, tk, 1'b1, tag);
        push(t, 1, s, 1'b0, tk, 1'b1, tag);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic step_to(input int c);
        while (cyc < c) step(1);
    endtask

    task automatic check_entry(input exp_t x);
        logic [6:0] s;
        logic       e, tk;
        s  = (x.unit == 0) ? seg10  : seg3;
        e  = (x.unit == 0) ? err10  : err3;
        tk = (x.unit == 0) ? tick10 : tick3;
        checks++;
        assert (x.cyc == cyc) else begin
            errors++;
            $error("FAIL %s stale: observed cyc %0d expected cyc %0d", x.tag, cyc, x.cyc);
        end
        checks++;
        assert (s === x.seg) else begin
            errors++;
            $error("FAIL %s seg u%0d cyc %0d: observed %b expected %b", x.tag, x.unit, cyc, s, x.seg);
        end
        checks++;
        assert (e === x.err) else begin
            errors++;
            $error("FAIL %s err u%0d cyc %0d: observed %b expected %b", x.tag, x.unit, cyc, e, x.err);
        end
        if (x.chk_tick) begin
            checks++;
            assert (tk === x.tick) else begin
                errors++;
                $error("FAIL %s tick u%0d cyc %0d: observed %b expected %b", x.tag, x.unit, cyc, tk, x.tick);
            end
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            check_entry(sb.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, observed cyc %0d expected < 10000", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int k, p, q;
        logic [6:0] up_seq [5];
        logic [6:0] g;

        rst   = 1'b1;
        floor = 4'd0;
        dir   = 2'b00;

        // 1. reset and idle
        step(1);
        push_both(cyc, G_OFF, 1'b0, "reset1");
        step(1);
        push_both(cyc, G_OFF, 1'b0, "reset2");
        rst = 1'b0;
        push(cyc + 1, 0, DIG[0], 1'b0, 1'b0, 1'b0, "release");
        push(cyc + 1, 1, DIG[0], 1'b0, 1'b0, 1'b0, "release");
        step(2);

        // 2. floor sweep; FLOORS=3 instance shows E from floor 3 upward
        for (int f = 0; f < 10; f++) begin
            floor = 4'(f);
            push(cyc + 2, 0, DIG[f], 1'b0, 1'b0, 1'b0, "sweep10");
            if (f < 3) push(cyc + 2, 1, DIG[f], 1'b0, 1'b0, 1'b0, "sweep3");
            else       push(cyc + 2, 1, G_E,    1'b1, 1'b0, 1'b0, "sweep3_oor");
            step(1);
        end
        floor = 4'd3;
        push(cyc + 2, 1, G_E,    1'b1, 1'b0, 1'b0, "oor_floor3");
        push(cyc + 2, 0, DIG[3], 1'b0, 1'b0, 1'b0, "floor3_ok10");
        step(3);

        // 3. up animation, 5 frames of TD cycles, tick on each last cycle
        floor = 4'd2;
        dir   = 2'b01;
        k = cyc;
        up_seq = '{G_BOT, G_MID, G_TOP, DIG[2], G_BOT};
        for (int fr = 0; fr < 5; fr++)
            for (int c = 0; c < TD; c++)
                push_both(k + 2 + fr * TD + c, up_seq[fr], (c == TD - 1), "up_anim");

        // 4. switch to down while in UP2 with count=1
        for (int c = 0; c < 3; c++) push_both(k + 22 + c, G_MID, 1'b0, "up2_before_dn");
        for (int c = 0; c < TD; c++) push_both(k + 25 + c, G_TOP, (c == TD - 1), "dn1");
        push_both(k + 29, G_MID, 1'b0, "dn2");
        step_to(k + 23);
        dir = 2'b10;
        step_to(k + 30);

        // 5. stop blink with an out-of-range floor on the FLOORS=3 instance
        floor = 4'd5;
        dir   = 2'b11;
        p = cyc;
        for (int fr = 0; fr < 4; fr++)
            for (int c = 0; c < TD; c++) begin
                g = (fr % 2 == 0) ? G_E : G_OFF;
                push(p + 2 + fr * TD + c, 1, g, 1'b1, (c == TD - 1), 1'b1, "stop3");
                g = (fr % 2 == 0) ? DIG[5] : G_OFF;
                push(p + 2 + fr * TD + c, 0, g, 1'b0, (c == TD - 1), 1'b1, "stop10");
            end
        step_to(p + 18);

        // 6. reset during UP3, then restart from IDLE with dir still up
        floor = 4'd2;
        dir   = 2'b01;
        q = cyc;
        for (int c = 0; c < TD; c++) push_both(q + 2 + c, G_BOT, (c == TD - 1), "up1_pre_rst");
        push_both(q + 10, G_TOP, 1'b0, "up3_pre_rst");
        push_both(q + 12, G_OFF, 1'b0, "rst_mid_anim");
        push_both(q + 13, DIG[0], 1'b0, "idle_after_rst");
        for (int c = 0; c < TD; c++) push_both(q + 14 + c, G_BOT, (c == TD - 1), "up1_after_rst");
        push_both(q + 18, G_MID, 1'b0, "up2_after_rst");
        step_to(q + 11);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step_to(q + 19);

        step(2);
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL drain: observed %0d pending expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
